// File: rtl/key_debounce_multi.sv
// ---------------------------------------------------------------------------
// key_debounce_multi
//
// Debounces N_KEYS independent mechanical keys. For each key the raw level is
// synchronised, converted to pressed-high, and tracked by a small FSM that
// produces a debounced level plus press, release and long-press pulses.
//
// Ports
//   BJ_clk      in   1        single clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   button_in   in   N_KEYS   raw asynchronous key levels
//   key_state   out  N_KEYS   debounced level, 1 = pressed
//   key_press   out  N_KEYS   1-cycle pulse when key_state rises
//   key_release out  N_KEYS   1-cycle pulse when key_state falls
//   key_long    out  N_KEYS   1-cycle pulse once per press after LONG_CNT cycles
//   key_any     out  1        OR of key_state
//
// Per-channel FSM
//   state        | meaning
//   -------------+---------------------------------------------------------
//   IDLE         | key released and debounced, counters cleared
//   PRESS_WAIT   | pressed samples being counted toward STABLE_CNT
//   PRESSED      | key pressed and debounced, hold counter running
//   RELEASE_WAIT | released samples being counted toward STABLE_CNT
// ---------------------------------------------------------------------------
module key_debounce_multi #(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned STABLE_CNT = 50000,
    parameter int unsigned LONG_CNT   = 1000000,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned IDLE_LEVEL = 1
) (
    input  logic              BJ_clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] button_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              key_any
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic             IDLE_BIT  = 1'(IDLE_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CNT - 1);
    // The first STABLE_CNT cycles of a press are spent debouncing, so the hold
    // counter only has to cover the remainder of the long-press interval.
    localparam logic [CNT_W-1:0] LONG_HOLD = CNT_W'(LONG_CNT - STABLE_CNT);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(LONG_CNT);

    for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch

        logic             sync1_q;
        logic             sync2_q;
        logic             pressed;

        logic [1:0]       state_q,   state_d;
        logic [CNT_W-1:0] cnt_q,     cnt_d;
        logic [CNT_W-1:0] hold_q,    hold_d;
        logic             level_q,   level_d;
        logic             press_q,   press_d;
        logic             release_q, release_d;
        logic             long_q,    long_d;

        always_ff @(posedge BJ_clk or posedge rst) begin
            if (rst) begin
                sync1_q <= IDLE_BIT;
                sync2_q <= IDLE_BIT;
            end else begin
                sync1_q <= button_in[g];
                sync2_q <= sync1_q;
            end
        end

        // A sample that differs from the idle level means the key is pressed.
        assign pressed = sync2_q ^ IDLE_BIT;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            hold_d    = hold_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (pressed) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!pressed) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_M1) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                        hold_d  = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end

                ST_PRESSED: begin
                    if (pressed) begin
                        if (hold_q != HOLD_SAT) begin
                            hold_d = hold_q + CNT_ONE;
                        end
                        // Only the crossing into LONG_HOLD fires; saturation
                        // above it guarantees a single pulse per press.
                        if (hold_q == LONG_HOLD - CNT_ONE) begin
                            long_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (pressed) begin
                        // Release glitch: resume the press with the hold count
                        // that was retained on entry.
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_M1) begin
                        state_d   = ST_IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = '0;
                        hold_d    = '0;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    hold_d  = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge BJ_clk or posedge rst) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                hold_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                hold_q    <= hold_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign key_state[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
    end

    assign key_any = |key_state;

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

    localparam int NK = 4;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic          BJ_clk;
    logic          rst;
    logic [NK-1:0] button_in;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;
    logic          key_any;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 0;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;
    ev_t exp_q[$];

    logic [NK-1:0] mon_v;
    int            mon_idx;

    key_debounce_multi #(
        .N_KEYS    (NK),
        .STABLE_CNT(4),
        .LONG_CNT  (12),
        .CNT_W     (8),
        .IDLE_LEVEL(1)
    ) dut (
        .BJ_clk     (BJ_clk),
        .rst        (rst),
        .button_in  (button_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_any    (key_any)
    );

    initial begin
        BJ_clk = 1'b0;
        forever #5 BJ_clk = ~BJ_clk;
    end

    always @(posedge BJ_clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match a pending expectation for
    // this exact cycle; any expectation not seen by its cycle is a miss.
    always @(negedge BJ_clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                mon_v = (k == K_PRESS) ? key_press : (k == K_REL) ? key_release : key_long;
                for (int c = 0; c < NK; c++) begin
                    if (mon_v[c]) begin
                        mon_idx = -1;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (mon_idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == k && exp_q[i].ch == c)
                                mon_idx = i;
                        end
                        n_tests++;
                        if (mon_idx < 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pulse: kind %0d ch %0d at cycle %0d, none expected", k, c, cyc);
                        end else begin
                            exp_q.delete(mon_idx);
                        end
                    end
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc <= cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missed_pulse: kind %0d ch %0d expected at cycle %0d, not seen by cycle %0d",
                             exp_q[i].kind, exp_q[i].ch, exp_q[i].cyc, cyc);
                    exp_q.delete(i);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge BJ_clk);
    endtask

    task automatic expect_ev(input int c, input int kind, input int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge BJ_clk);
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        tick(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        button_in = 4'hF;
        tick(3);
        n_tests++;
        if ({key_state, key_press, key_release, key_long, key_any} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {key_state, key_press, key_release, key_long, key_any});
        end
        button_in = 4'h0;
        tick(8);
        n_tests++;
        if ({key_state, key_press, key_release, key_long, key_any} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_hold_pressed: got %h required 0", {key_state, key_press, key_release, key_long, key_any});
        end
        button_in = 4'hF;
        tick(3);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(8);
        n_tests++;
        if (key_state !== 4'h0 || key_any !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: key_state %h key_any %b required 0 0", key_state, key_any);
        end
    endtask

    task automatic test_clean_press;
        int t;
        button_in[0] = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 0);
        expect_ev(t + 14, K_LONG, 0);
        tick(5);
        n_tests++;
        if (key_state[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_press_early: key_state[0] %b required 0", key_state[0]);
        end
        tick(1);
        n_tests++;
        if (key_state[0] !== 1'b1 || key_any !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_press_state: key_state[0] %b key_any %b required 1 1", key_state[0], key_any);
        end
        tick(14);
        button_in[0] = 1'b1;
        t = cyc;
        expect_ev(t + 6, K_REL, 0);
        tick(5);
        n_tests++;
        if (key_state[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_release_early: key_state[0] %b required 1", key_state[0]);
        end
        tick(1);
        n_tests++;
        if (key_state[0] !== 1'b0 || key_any !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release_state: key_state[0] %b key_any %b required 0 0", key_state[0], key_any);
        end
        wait_idle(20);
    endtask

    task automatic test_bounce;
        for (int r = 0; r < 5; r++) begin
            button_in[1] = 1'b0;
            tick(3);
            button_in[1] = 1'b1;
            tick(1);
            n_tests++;
            if (key_state[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_state: round %0d key_state[1] %b required 0", r, key_state[1]);
            end
        end
        tick(10);
        n_tests++;
        if (key_state[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_final: key_state[1] %b required 0", key_state[1]);
        end
        wait_idle(5);
    endtask

    task automatic test_min_pulse;
        int t;
        button_in[2] = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 2);
        tick(4);
        button_in[2] = 1'b1;
        expect_ev(cyc + 6, K_REL, 2);
        wait_idle(20);
        n_tests++;
        if (key_state[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL min_pulse_state: key_state[2] %b required 0", key_state[2]);
        end
    endtask

    task automatic test_long_press;
        int t;
        button_in[2] = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 2);
        expect_ev(t + 14, K_LONG, 2);
        tick(6);
        n_tests++;
        if (key_state[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL long_state: key_state[2] %b required 1", key_state[2]);
        end
        tick(30);
        button_in[2] = 1'b1;
        expect_ev(cyc + 6, K_REL, 2);
        wait_idle(20);
    endtask

    task automatic test_release_glitch;
        int t;
        button_in[0] = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 0);
        expect_ev(t + 14, K_LONG, 0);
        tick(20);
        button_in[0] = 1'b1;
        tick(2);
        button_in[0] = 1'b0;
        tick(12);
        // Longest tolerated glitch: one sample short of the debounce count.
        button_in[0] = 1'b1;
        tick(3);
        button_in[0] = 1'b0;
        tick(20);
        n_tests++;
        if (key_state[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_state: key_state[0] %b required 1", key_state[0]);
        end
        button_in[0] = 1'b1;
        expect_ev(cyc + 6, K_REL, 0);
        wait_idle(20);
    endtask

    task automatic test_simultaneous;
        int t;
        button_in[0] = 1'b0;
        button_in[3] = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 0);
        expect_ev(t + 6, K_PRESS, 3);
        expect_ev(t + 14, K_LONG, 0);
        expect_ev(t + 14, K_LONG, 3);
        tick(6);
        n_tests++;
        if (key_state !== 4'b1001 || key_any !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_state: key_state %b key_any %b required 1001 1", key_state, key_any);
        end
        tick(12);
        button_in[0] = 1'b1;
        button_in[3] = 1'b1;
        t = cyc;
        expect_ev(t + 6, K_REL, 0);
        expect_ev(t + 6, K_REL, 3);
        wait_idle(20);
        n_tests++;
        if (key_any !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_any_low: key_any %b required 0", key_any);
        end
    endtask

    task automatic test_reset_mid_press;
        int t;
        button_in[1] = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 1);
        tick(8);
        n_tests++;
        if (key_state[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_state: key_state[1] %b required 1", key_state[1]);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({key_state, key_press, key_release, key_long, key_any} !== 17'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %h required 0", {key_state, key_press, key_release, key_long, key_any});
        end
        tick(3);
        rst = 1'b0;
        t = cyc;
        expect_ev(t + 6, K_PRESS, 1);
        expect_ev(t + 14, K_LONG, 1);
        tick(5);
        n_tests++;
        if (key_state[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_redebounce: key_state[1] %b required 0", key_state[1]);
        end
        tick(12);
        button_in[1] = 1'b1;
        expect_ev(cyc + 6, K_REL, 1);
        wait_idle(20);
    endtask

    initial begin
        rst = 1'b1;
        button_in = 4'hF;
        tick(1);
        test_reset();
        test_clean_press();
        test_bounce();
        test_min_pulse();
        test_long_press();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4, meaning the number of independent key channels (1..32).
REQ-002 The block SHALL have parameter STABLE_CNT, default 50000, meaning the consecutive BJ_clk cycles required to accept a level change (2..2^CNT_W-1).
REQ-003 The block SHALL have parameter LONG_CNT, default 1000000, meaning the BJ_clk cycles a debounced press must persist before a long-press pulse (greater than STABLE_CNT).
REQ-004 The block SHALL have parameter CNT_W, default 24, meaning the counter width, which SHALL hold LONG_CNT.
REQ-005 The block SHALL have parameter IDLE_LEVEL, default 1, meaning the raw input level of a released key (1 = active-low keys).
REQ-006 The block SHALL have port BJ_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-008 The block SHALL have port button_in, input, N_KEYS bits: the raw asynchronous key levels.
REQ-009 The block SHALL have port key_state, output, N_KEYS bits: the debounced level, where 1 = pressed regardless of IDLE_LEVEL.
REQ-010 The block SHALL have port key_press, output, N_KEYS bits: a 1-cycle pulse when key_state rises.
REQ-011 The block SHALL have port key_release, output, N_KEYS bits: a 1-cycle pulse when key_state falls.
REQ-012 The block SHALL have port key_long, output, N_KEYS bits: a 1-cycle pulse once per press, after LONG_CNT cycles pressed.
REQ-013 The block SHALL have port key_any, output, 1 bit: the OR of all key_state bits.

Function
REQ-014 Each channel SHALL pass button_in through a 2-flop synchronizer and normalise the result to pressed-high (raw XOR IDLE_LEVEL inverted) before any further logic.
REQ-015 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus its own CNT_W-bit counter.
REQ-016 From IDLE, a sync pressed sample SHALL move the channel to PRESS_WAIT with counter=1, and a released sample SHALL keep it in IDLE with counter=0.
REQ-017 In PRESS_WAIT, a released sample SHALL return the channel to IDLE with counter=0 (bounce rejected, no pulse).
REQ-018 In PRESS_WAIT, a pressed sample with counter==STABLE_CNT-1 SHALL move the channel to PRESSED, set key_state=1, pulse key_press, and clear the counter; otherwise the counter SHALL increment.
REQ-019 In PRESSED, a pressed sample SHALL increment a saturating hold counter, and key_long SHALL pulse exactly on the cycle the hold counter reaches LONG_CNT-STABLE_CNT, never again in that press.
REQ-020 From PRESSED, a released sample SHALL move the channel to RELEASE_WAIT with counter=1, and the hold counter SHALL be retained.
REQ-021 In RELEASE_WAIT, a pressed sample SHALL return the channel to PRESSED and restore the hold count without re-pulsing key_long.
REQ-022 In RELEASE_WAIT, a released sample with counter==STABLE_CNT-1 SHALL move the channel to IDLE, set key_state=0, pulse key_release, and clear both counters.
REQ-023 Press and release latency from a clean input edge SHALL be exactly 2 (synchronizer) + STABLE_CNT cycles to the key_state change, with the key_press/key_release pulse in the same cycle as that change.
REQ-024 key_press, key_release and key_long SHALL be registered outputs, at most one of them high per channel per cycle except key_long, which may coincide with nothing else in the same channel.
REQ-025 Counters SHALL never wrap: the hold counter saturates at LONG_CNT, and debounce counters are bounded by the FSM.
REQ-026 Channels SHALL be fully independent, so simultaneous events on different channels each produce their own pulses in the same cycle.
REQ-027 key_any SHALL be registered-free combinational OR of key_state.

Reset
REQ-028 While rst=1, synchronizer flops SHALL hold IDLE_LEVEL, every FSM SHALL be in IDLE, all counters SHALL be 0, and key_state, key_press, key_release, key_long and key_any SHALL be 0.
REQ-029 Reset asserted mid-press SHALL clear the channel immediately with no key_release pulse, and a key still held after deassertion SHALL be re-debounced from IDLE.

Verification (N_KEYS=4, STABLE_CNT=4, LONG_CNT=12, IDLE_LEVEL=1)
REQ-030 Clean press: button_in[0] 1->0 and held -> key_state[0]=1 and a single key_press[0] pulse exactly 6 cycles later.
REQ-031 Bounce: button_in[1] toggles low for 3 cycles, high for 1, repeated 5 times -> no key_press[1] and key_state[1] stays 0.
REQ-032 Long press: hold key 2 for 30 cycles after key_state[2]=1 -> exactly one key_long[2] pulse, 8 cycles after key_press[2]; release -> key_release[2] 6 cycles after the release edge.
REQ-033 Release glitch: key 0 pressed, 2-cycle high glitch -> no key_release[0] and no second key_long[0].
REQ-034 Simultaneous press: keys 0 and 3 pressed in the same cycle -> key_press[0] and key_press[3] in the same cycle, and key_any=1.
REQ-035 Reset mid-press: rst pulsed while key_state[1]=1 -> all outputs 0 with no key_release[1], then key_press[1] again 6 cycles after rst falls while the key is still held.
